// File: rtl/dds_quarter_addr_gen_pkg.sv
// Shared encodings for the DDS quarter-wave address generator.
//   dir_e   : LUT walk direction (memdir)
//   pol_e   : output sign (data_pol)
//   state_e : sequencer state
package dds_quarter_addr_gen_pkg;

   typedef enum logic {FORWARD = 1'b0, BACKWARD = 1'b1} dir_e;
   typedef enum logic {POL_POS = 1'b0, POL_NEG  = 1'b1} pol_e;
   typedef enum logic {RUN     = 1'b0, WAIT_DIR = 1'b1} state_e;

   // Width of a down-counter that must hold values 0..n-1 (at least 1 bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dds_quarter_addr_gen_if.sv
// Quarter-wave LUT read bus.
//   lut_addr : registered read address (sequencer -> LUT)
//   lut_data : unsigned magnitude, valid LUT_LAT cycles after lut_addr (LUT -> sequencer)
interface dds_quarter_addr_gen_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 12
);
   logic [ADDR_W-1:0] lut_addr;
   logic [DATA_W-1:0] lut_data;

   modport master (output lut_addr, input  lut_data);
   modport slave  (input  lut_addr, output lut_data);
endinterface

// File: rtl/dds_quarter_addr_gen_sign_pipe.sv
// Sign stage: delays data_pol/enable to line up with the LUT read result,
// then registers the signed sample.
//   src_clk, rst      : clock, synchronous active-high reset
//   pol_in, en_in     : captured on the same edge as lut_addr
//   lut_data          : LUT magnitude
//   sample            : signed two's-complement sample (DATA_W+1 bits)
//   sample_valid      : sample qualifier
module dds_quarter_addr_gen_sign_pipe
   import dds_quarter_addr_gen_pkg::*;
#(
   parameter int DATA_W  = 12,
   parameter int LUT_LAT = 1
) (
   input  logic              src_clk,
   input  logic              rst,
   input  logic              pol_in,
   input  logic              en_in,
   input  logic [DATA_W-1:0] lut_data,
   output logic [DATA_W:0]   sample,
   output logic              sample_valid
);

   // Stage 0 sits beside lut_addr; stage LUT_LAT lines up with lut_data.
   logic [LUT_LAT:0] pol_q, pol_d;
   logic [LUT_LAT:0] en_q,  en_d;
   logic [DATA_W:0]  sample_q, sample_d;
   logic             valid_q, valid_d;

   always_comb begin
      pol_d    = {pol_q[LUT_LAT-1:0], pol_in};
      en_d     = {en_q[LUT_LAT-1:0], en_in};
      // Negating {0,0} yields 0, so there is no negative zero.
      sample_d = (pol_e'(pol_q[LUT_LAT]) == POL_NEG) ? -{1'b0, lut_data}
                                                     :  {1'b0, lut_data};
      valid_d  = en_q[LUT_LAT];
   end

   always_ff @(posedge src_clk) begin
      if (rst) begin
         pol_q    <= '0;
         en_q     <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         pol_q    <= pol_d;
         en_q     <= en_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;

endmodule

// File: rtl/dds_quarter_addr_gen.sv
// Quarter-wave LUT address sequencer and sign stage for the DDS sine path.
// Accumulates tune_word, walks the LUT forward/backward per memdir, pulses
// trigger on every quarter wrap and signs the LUT magnitude per data_pol.
//   src_clk, rst  : clock, synchronous active-high reset
//   enable        : advance phase; 0 freezes acc/state/timer/lut_addr
//   tune_word     : phase increment per enabled cycle
//   memdir        : 0 FORWARD, 1 BACKWARD
//   data_pol      : 0 POL_POS, 1 POL_NEG
//   trigger       : 1-cycle pulse, coincident with the wrapped lut_addr
//   sample(_valid): signed output sample and qualifier
//   dir_err       : sticky, memdir timeout or carry while waiting
//   lut_bus       : LUT read bus (master side)
// Build option: DDS_ADDR_ROUND_EN rounds the address on the top fraction bit,
// saturating at the last LUT entry instead of wrapping.
//
// state    | meaning
// RUN      | lut_addr follows the accumulator every enabled cycle
// WAIT_DIR | quarter wrapped; lut_addr held until memdir flips or timer expires
module dds_quarter_addr_gen
   import dds_quarter_addr_gen_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int FRAC_W      = 8,
   parameter int DATA_W      = 12,
   parameter int LUT_LAT     = 1,
   parameter int DIR_TIMEOUT = 4
) (
   input  logic                     src_clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [ADDR_W+FRAC_W-1:0] tune_word,
   input  logic                     memdir,
   input  logic                     data_pol,
   output logic                     trigger,
   output logic [DATA_W:0]          sample,
   output logic                     sample_valid,
   output logic                     dir_err,
   dds_quarter_addr_gen_if.master   lut_bus
);

   localparam int PH_W  = ADDR_W + FRAC_W;
   localparam int TMR_W = int'(cnt_w(DIR_TIMEOUT));

   logic [PH_W-1:0]   acc_q, acc_d;
   state_e            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              dir_q, dir_d;
   logic              trig_q, trig_d;
   logic              err_q, err_d;

   logic [PH_W:0]     sum;
   logic              carry;
   logic [PH_W-1:0]   acc_nxt;
   logic [ADDR_W-1:0] addr_src;
   logic [ADDR_W-1:0] addr_new;
`ifdef DDS_ADDR_ROUND_EN
   logic [ADDR_W:0]   addr_rnd;
`endif

   always_comb begin
      sum     = {1'b0, acc_q} + {1'b0, tune_word};
      carry   = sum[PH_W];
      acc_nxt = sum[PH_W-1:0];
`ifdef DDS_ADDR_ROUND_EN
      addr_rnd = {1'b0, acc_nxt[PH_W-1:FRAC_W]} + (ADDR_W+1)'(acc_nxt[FRAC_W-1]);
      // Rounding past the last entry saturates; the wrap belongs to the carry.
      addr_src = addr_rnd[ADDR_W] ? '1 : addr_rnd[ADDR_W-1:0];
`else
      addr_src = acc_nxt[PH_W-1:FRAC_W];
`endif
      addr_new = (memdir == BACKWARD) ? ~addr_src : addr_src;
   end

   always_comb begin
      acc_d   = acc_q;
      state_d = state_q;
      timer_d = timer_q;
      addr_d  = addr_q;
      dir_d   = dir_q;
      trig_d  = 1'b0;
      err_d   = err_q;
      if (enable) begin
         acc_d = acc_nxt;
         case (state_q)
            RUN: begin
               addr_d = addr_new;
               if (carry) begin
                  trig_d  = 1'b1;
                  dir_d   = memdir;
                  state_d = WAIT_DIR;
                  timer_d = TMR_W'(DIR_TIMEOUT - 1);
               end
            end
            WAIT_DIR: begin
               // Direction change beats a coincident carry, which still flags.
               if (memdir != dir_q) begin
                  state_d = RUN;
                  addr_d  = addr_new;
                  if (carry) err_d = 1'b1;
               end else if (carry) begin
                  err_d = 1'b1;
               end else if (timer_q == '0) begin
                  state_d = RUN;
                  err_d   = 1'b1;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge src_clk) begin
      if (rst) begin
         acc_q   <= '0;
         state_q <= RUN;
         timer_q <= '0;
         addr_q  <= '0;
         dir_q   <= FORWARD;
         trig_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         state_q <= state_d;
         timer_q <= timer_d;
         addr_q  <= addr_d;
         dir_q   <= dir_d;
         trig_q  <= trig_d;
         err_q   <= err_d;
      end
   end

   assign lut_bus.lut_addr = addr_q;
   assign trigger          = trig_q;
   assign dir_err          = err_q;

   dds_quarter_addr_gen_sign_pipe #(
      .DATA_W  (DATA_W),
      .LUT_LAT (LUT_LAT)
   ) u_sign_pipe (
      .src_clk      (src_clk),
      .rst          (rst),
      .pol_in       (data_pol),
      .en_in        (enable),
      .lut_data     (lut_bus.lut_data),
      .sample       (sample),
      .sample_valid (sample_valid)
   );

endmodule

// File: tb/tb_dds_quarter_addr_gen.sv
module tb_dds_quarter_addr_gen;

   localparam int ADDR_W      = 8;
   localparam int FRAC_W      = 8;
   localparam int DATA_W      = 12;
   localparam int LUT_LAT     = 1;
   localparam int DIR_TIMEOUT = 4;
   localparam int PH_W        = ADDR_W + FRAC_W;
   localparam int AMAX        = (1 << ADDR_W) - 1;
   localparam longint PH_MOD  = longint'(1) << PH_W;
   localparam int SMOD        = 1 << (DATA_W + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic [PH_W-1:0]   tune_word = '0;
   logic              memdir = 1'b0;
   logic              data_pol = 1'b0;
   logic              trigger;
   logic [DATA_W:0]   sample;
   logic              sample_valid;
   logic              dir_err;

   dds_quarter_addr_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lut_bus ();

   dds_quarter_addr_gen #(
      .ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W),
      .LUT_LAT(LUT_LAT), .DIR_TIMEOUT(DIR_TIMEOUT)
   ) dut (
      .src_clk      (clk),
      .rst          (rst),
      .enable       (enable),
      .tune_word    (tune_word),
      .memdir       (memdir),
      .data_pol     (data_pol),
      .trigger      (trigger),
      .sample       (sample),
      .sample_valid (sample_valid),
      .dir_err      (dir_err),
      .lut_bus      (lut_bus)
   );

   // LUT with LUT_LAT cycles of read latency
   logic [DATA_W-1:0] lut_mem  [0:AMAX];
   logic [DATA_W-1:0] lut_pipe [0:LUT_LAT-1];
   always @(posedge clk) begin
      lut_pipe[0] <= lut_mem[lut_bus.lut_addr];
      for (int i = 1; i < LUT_LAT; i++) lut_pipe[i] <= lut_pipe[i-1];
   end
   assign lut_bus.lut_data = lut_pipe[LUT_LAT-1];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: phase arithmetic plus "waiting for direction" bookkeeping
   longint m_phase;
   int     m_addr;
   bit     m_trig, m_wait, m_dirq, m_err;
   int     m_waited;
   int     cyc;
   int     h_addr [64];
   bit     h_pol  [64];
   bit     h_en   [64];

   function automatic int addr_of(input longint ph);
      int a;
      a = int'(ph >> FRAC_W);
`ifdef DDS_ADDR_ROUND_EN
      a = a + int'((ph >> (FRAC_W - 1)) & 1);
      if (a > AMAX) a = AMAX;
`endif
      return a;
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit md, input bit pl,
                             input int unsigned tw);
      longint s;
      bit     c;
      int     a;
      if (r) begin
         m_phase = 0; m_addr = 0; m_trig = 0; m_wait = 0; m_dirq = 0; m_err = 0;
         m_waited = 0; cyc = 0;
         h_addr[0] = 0; h_pol[0] = 0; h_en[0] = 0;
         return;
      end
      m_trig = 0;
      if (e) begin
         s = m_phase + longint'(tw);
         c = (s >= PH_MOD);
         s = s % PH_MOD;
         a = md ? AMAX - addr_of(s) : addr_of(s);
         if (!m_wait) begin
            m_addr = a;
            if (c) begin
               m_trig = 1; m_wait = 1; m_dirq = md; m_waited = 0;
            end
         end else if (md != m_dirq) begin
            m_wait = 0; m_addr = a;
            if (c) m_err = 1;
         end else if (c) begin
            m_err = 1;
         end else begin
            m_waited++;
            if (m_waited == DIR_TIMEOUT) begin
               m_wait = 0; m_err = 1;
            end
         end
         m_phase = s;
      end
      cyc++;
      h_addr[cyc % 64] = m_addr;
      h_pol[cyc % 64]  = pl;
      h_en[cyc % 64]   = e;
   endtask

   task automatic check_all();
      int idx, v, es;
      chk("lut_addr", longint'(lut_bus.lut_addr), m_addr);
      chk("trigger",  longint'(trigger), m_trig);
      chk("dir_err",  longint'(dir_err), m_err);
      if (cyc == 0) begin
         chk("sample_rst", longint'(sample), 0);
         chk("valid_rst",  longint'(sample_valid), 0);
      end else if (cyc <= LUT_LAT) begin
         chk("valid_fill", longint'(sample_valid), 0);
      end else begin
         idx = (cyc - LUT_LAT - 1) % 64;
         v   = int'(lut_mem[h_addr[idx]]);
         es  = h_pol[idx] ? (SMOD - v) % SMOD : v;
         chk("sample_valid", longint'(sample_valid), h_en[idx]);
         chk("sample",       longint'(sample), es);
      end
   endtask

   task automatic step(input bit r, input bit e, input bit md, input bit pl,
                       input int unsigned tw);
      rst = r; enable = e; memdir = md; data_pol = pl; tune_word = tw[PH_W-1:0];
      @(posedge clk);
      model_edge(r, e, md, pl, tw);
      #1;
      check_all();
   endtask

   typedef struct {
      bit          r, e, md;
      int unsigned tw;
      int          exp_addr;
      bit          exp_trig, exp_err;
   } vec_t;
   vec_t tbl [18];

   initial begin : main
      bit          md_r;
      int unsigned tw_r;
      bit          got;

      for (int i = 0; i <= AMAX; i++) lut_mem[i] = DATA_W'($urandom);
      lut_mem[1] = 12'h7FF;
      lut_mem[2] = 12'h000;

      //           r  e  md tw        addr trig err
      tbl[0]  = '{1, 0, 0, 0,        0,   0, 0};
      tbl[1]  = '{0, 1, 0, 'h4000,   64,  0, 0};
      tbl[2]  = '{0, 1, 0, 'h4000,   128, 0, 0};
      tbl[3]  = '{0, 1, 0, 'h4000,   192, 0, 0};
      tbl[4]  = '{0, 1, 0, 'h4000,   0,   1, 0};
      tbl[5]  = '{0, 1, 0, 'h4000,   0,   0, 0};
      tbl[6]  = '{0, 1, 1, 'h4000,   127, 0, 0};
      tbl[7]  = '{0, 1, 1, 'h4000,   63,  0, 0};
      tbl[8]  = '{0, 1, 1, 'h4000,   255, 1, 0};
      tbl[9]  = '{0, 0, 1, 'h4000,   255, 0, 0};
      tbl[10] = '{0, 1, 1, 'h4000,   255, 0, 0};
      tbl[11] = '{0, 1, 1, 'h4000,   255, 0, 0};
      tbl[12] = '{0, 1, 1, 'h4000,   255, 0, 0};
      tbl[13] = '{0, 1, 1, 'h4000,   255, 0, 1};
      tbl[14] = '{0, 1, 1, 'h4000,   255, 0, 1};
      tbl[15] = '{0, 1, 1, 'h4000,   127, 0, 1};
      tbl[16] = '{1, 1, 1, 'h4000,   0,   0, 0};
      tbl[17] = '{0, 1, 0, 'h4000,   64,  0, 0};

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].md, 1'b0, tbl[i].tw);
         chk($sformatf("tbl%0d_addr", i), longint'(lut_bus.lut_addr), tbl[i].exp_addr);
         chk($sformatf("tbl%0d_trig", i), longint'(trigger), tbl[i].exp_trig);
         chk($sformatf("tbl%0d_err",  i), longint'(dir_err), tbl[i].exp_err);
      end

      // Forward walk 1..255,0 with a single trigger on the 256th add
      step(1, 0, 0, 0, 0);
      for (int i = 1; i <= 256; i++) begin
         step(0, 1, 0, 0, 'h0100);
         chk($sformatf("walk%0d_addr", i), longint'(lut_bus.lut_addr), i % 256);
         chk($sformatf("walk%0d_trig", i), longint'(trigger), (i == 256) ? 1 : 0);
      end
      // Hold at 0 for two cycles, then walk backward from 253
      step(0, 1, 0, 0, 'h0100);
      chk("hold_addr", longint'(lut_bus.lut_addr), 0);
      step(0, 1, 1, 0, 'h0100);
      chk("back_addr0", longint'(lut_bus.lut_addr), 253);
      step(0, 1, 1, 0, 'h0100);
      chk("back_addr1", longint'(lut_bus.lut_addr), 252);
      chk("back_err", longint'(dir_err), 0);

      // Run to the next wrap, then leave memdir alone until the timeout
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         step(0, 1, 1, 0, 'h0100);
         got = trigger;
      end
      chk("wrap_seen", longint'(got), 1);
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 1, 0, 'h0100);
         chk($sformatf("wait%0d_err", i), longint'(dir_err), 0);
         chk($sformatf("wait%0d_addr", i), longint'(lut_bus.lut_addr), 255);
      end
      step(0, 1, 1, 0, 'h0100);
      chk("timeout_err", longint'(dir_err), 1);
      step(0, 1, 1, 0, 'h0100);
      chk("resume_addr", longint'(lut_bus.lut_addr), 250);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 'h0100);
      chk("err_sticky", longint'(dir_err), 1);

      // Negative sample of 0x7FF, then -0 must read back as 0
      step(1, 0, 0, 1, 0);
      step(0, 1, 0, 1, 'h0100);
      chk("neg_addr", longint'(lut_bus.lut_addr), 1);
      step(0, 1, 0, 1, 'h0100);
      chk("neg_valid_early", longint'(sample_valid), 0);
      step(0, 1, 0, 1, 'h0100);
      chk("neg_sample", longint'(sample), 'h1801);
      chk("neg_valid", longint'(sample_valid), 1);
      step(0, 1, 0, 1, 'h0100);
      chk("neg_zero", longint'(sample), 0);

      // Second carry while waiting: no trigger, error flagged
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 'hFF00);
      step(0, 1, 0, 0, 'hFF00);
      chk("fast_trig1", longint'(trigger), 1);
      chk("fast_addr1", longint'(lut_bus.lut_addr), 254);
      step(0, 1, 0, 0, 'hFF00);
      chk("fast_trig2", longint'(trigger), 0);
      chk("fast_err", longint'(dir_err), 1);
      chk("fast_addr2", longint'(lut_bus.lut_addr), 254);

      // Reset while waiting
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 'h8000);
      step(0, 1, 0, 0, 'h8000);
      chk("wrst_trig_pre", longint'(trigger), 1);
      step(1, 1, 0, 0, 'h8000);
      chk("wrst_addr", longint'(lut_bus.lut_addr), 0);
      chk("wrst_trig", longint'(trigger), 0);
      chk("wrst_sample", longint'(sample), 0);
      chk("wrst_valid", longint'(sample_valid), 0);
      chk("wrst_err", longint'(dir_err), 0);
      step(0, 1, 0, 0, 'h0100);
      chk("wrst_addr1", longint'(lut_bus.lut_addr), 1);
      chk("wrst_trig1", longint'(trigger), 0);

      // Randomized run against the model
      md_r = 0;
      tw_r = 'h0300;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 3))
               0: tw_r = $urandom_range(1, 8) << FRAC_W;
               1: tw_r = $urandom_range(0, 32'hFFFF);
               2: tw_r = 32'hFF00 + $urandom_range(0, 255);
               default: tw_r = $urandom_range(0, 32'h0FFF);
            endcase
         end
         if ($urandom_range(0, 5) == 0) md_r = ~md_r;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, md_r,
              1'($urandom_range(0, 1)), tw_r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
